// File: rtl/pixel_write_buffer_pkg.sv
// pixel_write_buffer_pkg: shared widths, queue entry format and control states for the pixel write buffer.
package pixel_write_buffer_pkg;
    localparam int ADDR_BITS        = 16;
    localparam int COLOR_BITS       = 4;
    localparam int PIXEL_FIFO_DEPTH = 16;

    typedef struct packed {
        logic                  is_pixel;
        logic                  swap_after;
        logic [ADDR_BITS-1:0]  addr;
        logic [COLOR_BITS-1:0] color;
    } pixel_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_SWAP_WAIT
    } state_t;
endpackage

// File: rtl/pixel_write_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered level; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       push_in,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic [$clog2(DEPTH+1)-1:0] level_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign full_out  = (r_level == LW'(DEPTH));
    assign empty_out = (r_level == '0);
    assign level_out = r_level;
    assign data_out  = r_mem[r_rptr];
    assign w_push    = push_in && !full_out;
    assign w_pop     = pop_in && !empty_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_level <= (w_push && !w_pop) ? r_level + 1'b1 :
                       (!w_push && w_pop) ? r_level - 1'b1 : r_level;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wptr] <= data_in;
    end
endmodule

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: elastic queue of pixel writes that turns frame markers into swap pulses
// issued only after every earlier pixel has been written.
module pixel_write_buffer
    import pixel_write_buffer_pkg::*;
#(
    parameter int DEPTH      = PIXEL_FIFO_DEPTH,
    parameter int ADDR_LEN   = ADDR_BITS,
    parameter int DATA_WIDTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       pixel_valid_in,
    input  logic [ADDR_LEN-1:0]        pixel_addr_in,
    input  logic [DATA_WIDTH-1:0]      pixel_color_in,
    input  logic                       new_frame_in,
    input  logic                       stall_in,
    output logic                       ready_out,
    output logic                       write_enable_out,
    output logic [ADDR_LEN-1:0]        write_addr_out,
    output logic [DATA_WIDTH-1:0]      write_data_out,
    output logic                       swap_out,
    output logic [$clog2(DEPTH+1)-1:0] level_out,
    output logic                       overflow_out
);
    typedef struct packed {
        logic                  is_pixel;
        logic                  swap_after;
        logic [ADDR_LEN-1:0]   addr;
        logic [DATA_WIDTH-1:0] color;
    } entry_t;

    localparam int EW = $bits(entry_t);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_swap_pending;
    logic          w_swap_pending_nxt;
    logic          w_overflow_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    entry_t        w_push_entry;
    entry_t        w_head;
    logic [EW-1:0] w_head_bits;

    assign w_head    = entry_t'(w_head_bits);
    assign ready_out = !w_full;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push_in   (w_push),
        .data_in   (w_push_entry),
        .pop_in    (w_pop),
        .data_out  (w_head_bits),
        .full_out  (w_full),
        .empty_out (w_empty),
        .level_out (level_out)
    );

    // A deferred marker owns the first free slot; a marker arriving meanwhile becomes the new pending one.
    always_comb begin
        w_push             = 1'b0;
        w_push_entry       = '0;
        w_swap_pending_nxt = r_swap_pending;
        w_overflow_nxt     = overflow_out;
        if (r_swap_pending && !w_full) begin
            w_push                  = 1'b1;
            w_push_entry.swap_after = 1'b1;
            w_swap_pending_nxt      = new_frame_in;
            w_overflow_nxt          = overflow_out || pixel_valid_in;
        end else if (w_full) begin
            w_overflow_nxt     = overflow_out || pixel_valid_in || (new_frame_in && r_swap_pending);
            w_swap_pending_nxt = r_swap_pending || new_frame_in;
        end else if (pixel_valid_in || new_frame_in) begin
            w_push                  = 1'b1;
            w_push_entry.is_pixel   = pixel_valid_in;
            w_push_entry.swap_after = new_frame_in;
            w_push_entry.addr       = pixel_valid_in ? pixel_addr_in : '0;
            w_push_entry.color      = pixel_valid_in ? pixel_color_in : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (r_state == ST_RUN) begin
            w_pop       = !w_empty && !stall_in;
            w_state_nxt = (w_pop && w_head.swap_after) ? ST_SWAP_WAIT : ST_RUN;
        end else begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state          <= ST_RUN;
            r_swap_pending   <= 1'b0;
            overflow_out     <= 1'b0;
            write_enable_out <= 1'b0;
            write_addr_out   <= '0;
            write_data_out   <= '0;
            swap_out         <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_swap_pending   <= w_swap_pending_nxt;
            overflow_out     <= w_overflow_nxt;
            write_enable_out <= w_pop && w_head.is_pixel;
            write_addr_out   <= w_pop ? w_head.addr : write_addr_out;
            write_data_out   <= w_pop ? w_head.color : write_data_out;
            swap_out         <= (r_state == ST_SWAP_WAIT);
        end
    end
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb_pixel_write_buffer: directed scenarios plus randomized traffic checked every cycle against a queue-based model.
module tb_pixel_write_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        pixel_valid_in = 1'b0;
    logic [15:0] pixel_addr_in = '0;
    logic [3:0]  pixel_color_in = '0;
    logic        new_frame_in = 1'b0;
    logic        stall_in = 1'b0;
    logic        ready_out;
    logic        write_enable_out;
    logic [15:0] write_addr_out;
    logic [3:0]  write_data_out;
    logic        swap_out;
    logic [4:0]  level_out;
    logic        overflow_out;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pixel_write_buffer dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n_in),
        .pixel_valid_in   (pixel_valid_in),
        .pixel_addr_in    (pixel_addr_in),
        .pixel_color_in   (pixel_color_in),
        .new_frame_in     (new_frame_in),
        .stall_in         (stall_in),
        .ready_out        (ready_out),
        .write_enable_out (write_enable_out),
        .write_addr_out   (write_addr_out),
        .write_data_out   (write_data_out),
        .swap_out         (swap_out),
        .level_out        (level_out),
        .overflow_out     (overflow_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of pending entries, a deferred-marker flag and a one-cycle swap gap.
    typedef struct {
        bit          p;
        bit          s;
        logic [15:0] a;
        logic [3:0]  c;
    } ent_t;

    ent_t        q[$];
    ent_t        h;
    ent_t        e;
    bit          m_pend, m_ovf, m_gap, popped, push, full;
    bit          e_we, e_swap;
    logic [15:0] e_addr;
    logic [3:0]  e_data;

    always @(posedge clk) begin
        if (!rst_n_in) begin
            q.delete();
            m_pend = 0; m_ovf = 0; m_gap = 0;
            e_we = 0; e_swap = 0; e_addr = '0; e_data = '0;
        end else begin
            full   = (q.size() == DEPTH);
            popped = !m_gap && q.size() != 0 && !stall_in;
            if (popped) h = q[0];
            push = 0;
            e    = '{0, 0, 16'h0, 4'h0};
            if (m_pend && !full) begin
                push = 1;
                e.s  = 1;
                m_pend = new_frame_in;
                if (pixel_valid_in) m_ovf = 1;
            end else if (full) begin
                if (pixel_valid_in) m_ovf = 1;
                if (new_frame_in) begin
                    if (m_pend) m_ovf = 1;
                    m_pend = 1;
                end
            end else if (pixel_valid_in || new_frame_in) begin
                push = 1;
                e = '{pixel_valid_in, new_frame_in, pixel_valid_in ? pixel_addr_in : 16'h0,
                      pixel_valid_in ? pixel_color_in : 4'h0};
            end
            e_swap = m_gap;
            m_gap  = popped && h.s;
            e_we   = popped && h.p;
            if (popped) begin
                e_addr = h.a;
                e_data = h.c;
                void'(q.pop_front());
            end
            if (push) q.push_back(e);
        end
        #1;
        chk("write_enable", 32'(write_enable_out), 32'(e_we));
        chk("write_addr", 32'(write_addr_out), 32'(e_addr));
        chk("write_data", 32'(write_data_out), 32'(e_data));
        chk("swap", 32'(swap_out), 32'(e_swap));
        chk("level", 32'(level_out), 32'(q.size()));
        chk("ready", 32'(ready_out), 32'(q.size() < DEPTH));
        chk("overflow", 32'(overflow_out), 32'(m_ovf));
    end

    task automatic cyc(input bit pv, input logic [15:0] a, input logic [3:0] c, input bit nf, input bit st);
        @(negedge clk);
        pixel_valid_in = pv;
        pixel_addr_in  = a;
        pixel_color_in = c;
        new_frame_in   = nf;
        stall_in       = st;
    endtask

    task automatic idle(input bit st);
        cyc(0, 16'h0, 4'h0, 0, st);
    endtask

    initial begin
        int wr, sw, last_wr, first_sw, prev_sw;
        #1 rst_n_in = 1'b0;
        #1;
        chk("reset_ready", 32'(ready_out), 32'd1);
        chk("reset_level", 32'(level_out), 32'd0);
        chk("reset_we", 32'(write_enable_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n_in = 1'b1;

        // single pixel: write in cycle 2 only
        cyc(1, 16'h0123, 4'hA, 0, 0);
        idle(0);
        chk("single_level_c1", 32'(level_out), 32'd1);
        chk("single_we_c1", 32'(write_enable_out), 32'd0);
        idle(0);
        chk("single_we_c2", 32'(write_enable_out), 32'd1);
        chk("single_addr_c2", 32'(write_addr_out), 32'h0123);
        chk("single_data_c2", 32'(write_data_out), 32'hA);
        chk("single_level_c2", 32'(level_out), 32'd0);
        idle(0);
        chk("single_we_c3", 32'(write_enable_out), 32'd0);

        // ordering: writes in cycles 2..5, swap in cycle 6 only
        cyc(1, 16'd1, 4'd1, 0, 0);
        cyc(1, 16'd2, 4'd2, 0, 0);
        cyc(1, 16'd3, 4'd3, 0, 0);
        chk("order_addr_c2", 32'(write_addr_out), 32'd1);
        cyc(1, 16'd4, 4'd4, 1, 0);
        chk("order_addr_c3", 32'(write_addr_out), 32'd2);
        idle(0);
        idle(0);
        chk("order_addr_c5", 32'(write_addr_out), 32'd4);
        chk("order_we_c5", 32'(write_enable_out), 32'd1);
        chk("order_swap_c5", 32'(swap_out), 32'd0);
        idle(0);
        chk("order_swap_c6", 32'(swap_out), 32'd1);
        chk("order_we_c6", 32'(write_enable_out), 32'd0);
        idle(0);
        chk("order_swap_c7", 32'(swap_out), 32'd0);

        // stall: 10 queued, then drained in order
        for (int i = 0; i < 10; i++) cyc(1, 16'(i + 16), 4'(i), 0, 1);
        idle(1);
        chk("stall_level", 32'(level_out), 32'd10);
        chk("stall_we", 32'(write_enable_out), 32'd0);
        idle(0);
        for (int i = 0; i < 10; i++) begin
            idle(0);
            chk("drain_we", 32'(write_enable_out), 32'd1);
            chk("drain_addr", 32'(write_addr_out), 32'(i + 16));
        end
        idle(0);
        chk("drain_level", 32'(level_out), 32'd0);

        // overflow: 17th pixel dropped, marker while full survives
        for (int i = 0; i < 17; i++) cyc(1, 16'(i + 100), 4'(i), 0, 1);
        idle(1);
        chk("ovf_flag", 32'(overflow_out), 32'd1);
        chk("ovf_ready", 32'(ready_out), 32'd0);
        chk("ovf_level", 32'(level_out), 32'd16);
        cyc(0, 16'h0, 4'h0, 1, 1);
        idle(1);
        wr = 0; sw = 0; last_wr = 0; first_sw = 0;
        for (int i = 0; i < 30; i++) begin
            idle(0);
            if (write_enable_out) begin wr++; last_wr = i; end
            if (swap_out) begin sw++; first_sw = i; end
        end
        chk("ovf_writes", 32'(wr), 32'd16);
        chk("ovf_swaps", 32'(sw), 32'd1);
        chk("ovf_swap_after_writes", 32'(first_sw > last_wr), 32'd1);
        chk("ovf_sticky", 32'(overflow_out), 32'd1);

        // reset while in swap wait with 5 entries queued
        cyc(0, 16'h0, 4'h0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 16'(i + 200), 4'(i), 0, 1);
        idle(0);
        @(negedge clk);
        chk("rst_level_before", 32'(level_out), 32'd5);
        rst_n_in = 1'b0;
        #1;
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_swap", 32'(swap_out), 32'd0);
        chk("rst_ovf", 32'(overflow_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);
        @(negedge clk);
        rst_n_in = 1'b1;
        sw = 0;
        for (int i = 0; i < 6; i++) begin idle(0); sw += int'(swap_out); end
        chk("rst_no_swap", 32'(sw), 32'd0);

        // back-to-back markers
        cyc(0, 16'h0, 4'h0, 1, 0);
        idle(0);
        cyc(0, 16'h0, 4'h0, 1, 0);
        wr = 0; sw = 0; prev_sw = -5; first_sw = 1;
        for (int i = 0; i < 10; i++) begin
            idle(0);
            wr += int'(write_enable_out);
            if (swap_out) begin
                sw++;
                if (i - prev_sw < 2) first_sw = 0;
                prev_sw = i;
            end
        end
        chk("b2b_swaps", 32'(sw), 32'd2);
        chk("b2b_writes", 32'(wr), 32'd0);
        chk("b2b_separate", 32'(first_sw), 32'd1);

        // randomized traffic with stall bursts and rare resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n_in       = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 11) == 0) stall_in = ~stall_in;
            pixel_valid_in = ($urandom_range(0, 9) < 7);
            pixel_addr_in  = 16'($urandom);
            pixel_color_in = 4'($urandom);
            new_frame_in   = ($urandom_range(0, 14) == 0);
        end
        @(negedge clk);
        rst_n_in = 1'b1;
        for (int i = 0; i < 60; i++) idle(0);
        chk("final_level", 32'(level_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
